regfile_2r1w_sb: RTL
====================

// Module: regfile_2r1w_sb
// PURPOSE
//  Clocked general-purpose register file for the RISC-V core: NREGS x XLEN storage, two
//  combinational read ports (rs1/rs2) and one synchronous write port (rd). Register 0 is
//  hard-wired to zero. Optional write-through bypass and a per-register busy scoreboard
//  for stall detection in the pipelined datapath. Sits between decode (reads, issue) and
//  writeback (writes).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of two, >= 2)
//  AW      5   address width; must equal $clog2(NREGS)
//  BYPASS  1   1 = same-cycle write data forwarded to read ports; 0 = reads see stored value
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     asynchronous reset, active-high
//  rs1_addr   in   AW    read port 1 address
//  rs1_data   out  XLEN  read port 1 data (combinational)
//  rs1_busy   out  1     scoreboard bit of rs1_addr (combinational)
//  rs2_addr   in   AW    read port 2 address
//  rs2_data   out  XLEN  read port 2 data (combinational)
//  rs2_busy   out  1     scoreboard bit of rs2_addr (combinational)
//  we         in   1     write enable
//  rd_addr    in   AW    write address
//  rd_data    in   XLEN  write data
//  iss_en     in   1     issue: mark iss_addr busy (pending writeback)
//  iss_addr   in   AW    destination register of issuing instruction
//  any_busy   out  1     OR of all busy bits (used to drain before CSR/fence)
// BEHAVIOUR
//  - Reset (rst=1, async): all registers <= 0, all busy bits <= 0; held while rst=1.
//    Outputs therefore read 0 / not-busy for any address during and after reset.
//  - Write: at posedge clk with we=1 and rd_addr!=0, reg[rd_addr] <= rd_data.
//    we=1 with rd_addr==0 is discarded; reg[0] reads 0 always.
//  - Read: rsN_data = (rsN_addr==0) ? 0 : reg[rsN_addr], zero latency.
//    BYPASS=1: if we=1, rd_addr==rsN_addr and rd_addr!=0, rsN_data = rd_data same cycle.
//    BYPASS=0: new value visible the cycle after the write edge.
//  - Both read ports independent; rs1_addr==rs2_addr returns identical data.
//  - Scoreboard, per register i!=0, at posedge clk:
//      set   = iss_en & iss_addr==i ; clr = we & rd_addr==i
//      set&clr -> busy stays 1 (new producer wins); set -> 1; clr -> 0; else hold.
//    busy[0] is constant 0; iss_en with iss_addr==0 ignored.
//  - rsN_busy = busy[rsN_addr]; BYPASS=1 also forces rsN_busy=0 when the same-cycle write
//    clears that register and no same-cycle issue targets it.
//  - Clear of a non-busy register is legal (no error, no state change besides data).
//  - rst asserted mid-operation aborts any in-flight write/issue that edge; no partial update.
//  - No X propagation: X/Z on addresses is not special-cased; bench drives known values.
// TESTING
//  1 rst pulse then read all 32 addrs -> every rs1_data/rs2_data=0, any_busy=0.
//  2 we=1 rd=5 data=0xDEADBEEF; next cycle rs1=5,rs2=5 -> both 0xDEADBEEF.
//  3 we=1 rd=0 data=0xFFFFFFFF; rs1=0 same and next cycle -> 0x00000000.
//  4 BYPASS=1: we=1 rd=7 data=0x12345678 with rs2=7 same cycle -> rs2_data=0x12345678;
//    BYPASS=0 build -> old value 0 that cycle, 0x12345678 next.
//  5 iss rd=3 -> next cycle rs1=3 busy=1, any_busy=1; issue 3 and write 3 same edge ->
//    busy stays 1; write 3 alone -> busy=0, any_busy=0.
//  6 write 0xA5A5A5A5 to r9, assert rst mid-cycle (async) -> r9 reads 0 immediately.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// Register file with two combinational read ports and one synchronous write port.
// Register 0 reads as zero. Includes optional write-through bypass and a per-register busy scoreboard.
module regfile_2r1w_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            any_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic rs1_hit, rs2_hit;
    logic rs1_iss, rs2_iss;

    // NOTE: the storage array sits on the async reset because every register must read 0
    // after reset; this rules out a RAM macro but matches the architectural requirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (we && rd_addr != '0) begin
                regs[rd_addr] <= rd_data;
            end
            busy[0] <= 1'b0;
            // An issue on the same edge as a writeback wins: the new producer still owes a value.
            for (int i = 1; i < NREGS; i++) begin
                if (iss_en && iss_addr == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (we && rd_addr == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign rs1_hit = (BYPASS != 0) && we && (rd_addr == rs1_addr) && (rs1_addr != '0);
    assign rs2_hit = (BYPASS != 0) && we && (rd_addr == rs2_addr) && (rs2_addr != '0);
    assign rs1_iss = iss_en && (iss_addr == rs1_addr);
    assign rs2_iss = iss_en && (iss_addr == rs2_addr);

    assign rs1_data = (rs1_addr == '0) ? '0 : (rs1_hit ? rd_data : regs[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (rs2_hit ? rd_data : regs[rs2_addr]);

    // A forwarded writeback also retires the hazard, unless a new issue re-claims the register.
    assign rs1_busy = busy[rs1_addr] & ~(rs1_hit & ~rs1_iss);
    assign rs2_busy = busy[rs2_addr] & ~(rs2_hit & ~rs2_iss);

    assign any_busy = |busy;

endmodule
